// File: rtl/flag_update_controller_pkg.sv
// Shared definitions for the flag update controller: flag bit positions,
// branch condition-code encodings and FSM state encoding.
package flag_update_controller_pkg;

   localparam int FLG_C = 0;
   localparam int FLG_Z = 1;
   localparam int FLG_V = 2;
   localparam int FLG_N = 3;

   typedef enum logic [3:0] {
      CC_EQ = 4'd0,
      CC_NE = 4'd1,
      CC_CS = 4'd2,
      CC_CC = 4'd3,
      CC_MI = 4'd4,
      CC_PL = 4'd5,
      CC_VS = 4'd6,
      CC_VC = 4'd7,
      CC_HI = 4'd8,
      CC_LS = 4'd9,
      CC_GE = 4'd10,
      CC_LT = 4'd11,
      CC_GT = 4'd12,
      CC_LE = 4'd13,
      CC_AL = 4'd14,
      CC_NV = 4'd15
   } cc_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_ALU = 2'd1,
      ST_UPD_DONE = 2'd2,
      ST_EVAL     = 2'd3
   } state_e;

endpackage

// File: rtl/flag_update_controller_branch_cond_eval.sv
// Combinational branch condition evaluator: maps a 4-bit condition code and
// the committed {N,V,Z,C} flags to a taken/not-taken decision.
module flag_update_controller_branch_cond_eval
   import flag_update_controller_pkg::*;
#(
   parameter int NFLAGS = 4
)(
   input  logic [3:0]        cc,
   input  logic [NFLAGS-1:0] flags,
   output logic              taken
);

   logic flag_c;
   logic flag_z;
   logic flag_v;
   logic flag_n;

   assign flag_c = flags[FLG_C];
   assign flag_z = flags[FLG_Z];
   assign flag_v = flags[FLG_V];
   assign flag_n = flags[FLG_N];

   always_comb begin
      taken = 1'b0;
      case (cc_e'(cc))
         CC_EQ: taken = flag_z;
         CC_NE: taken = !flag_z;
         CC_CS: taken = flag_c;
         CC_CC: taken = !flag_c;
         CC_MI: taken = flag_n;
         CC_PL: taken = !flag_n;
         CC_VS: taken = flag_v;
         CC_VC: taken = !flag_v;
         CC_HI: taken = flag_c && !flag_z;
         CC_LS: taken = !flag_c || flag_z;
         CC_GE: taken = (flag_n == flag_v);
         CC_LT: taken = (flag_n != flag_v);
         CC_GT: taken = !flag_z && (flag_n == flag_v);
         CC_LE: taken = flag_z || (flag_n != flag_v);
         CC_AL: taken = 1'b1;
         CC_NV: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_update_controller.sv
// Flag update controller: sequences masked ALU flag commits and branch condition
// evaluation. Define FLAG_STACK_EN to add the interrupt flag shadow stack.
module flag_update_controller
   import flag_update_controller_pkg::*;
#(
   parameter int NFLAGS = 4
`ifdef FLAG_STACK_EN
   , parameter int STACK_DEPTH = 4
`endif
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NFLAGS-1:0] cond_values,
   input  logic              alu_done,
   input  logic              upd_req,
   input  logic [NFLAGS-1:0] upd_mask,
   output logic              upd_ack,
   input  logic              eval_req,
   input  logic [3:0]        cc,
   output logic              eval_valid,
   output logic              branch_taken,
   output logic [NFLAGS-1:0] flags,
   output logic              busy
`ifdef FLAG_STACK_EN
   ,
   input  logic              int_enter,
   input  logic              int_return,
   output logic              stack_err
`endif
);

   state_e            state_q;
   logic [NFLAGS-1:0] flags_q;
   logic [NFLAGS-1:0] mask_q;
   logic              upd_ack_q;
   logic              eval_valid_q;
   logic              branch_taken_q;
   logic              busy_q;
   logic [NFLAGS-1:0] flags_merge_d;
   logic              taken;

   // Only the masked bits take the live ALU flags; the rest keep their value.
   assign flags_merge_d = (flags_q & ~mask_q) | (cond_values & mask_q);

   flag_update_controller_branch_cond_eval #(
      .NFLAGS (NFLAGS)
   ) u_cond_eval (
      .cc     (cc),
      .flags  (flags_q),
      .taken  (taken)
   );

`ifdef FLAG_STACK_EN
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

   logic [NFLAGS-1:0] stack_mem [STACK_DEPTH];
   logic [SP_W-1:0]   sp_q;
   logic              stack_err_q;
   logic [IDX_W-1:0]  push_idx;
   logic [IDX_W-1:0]  top_idx;
   logic              stack_full;
   logic              stack_empty;
   logic              push_en;

   assign stack_full  = (sp_q == SP_FULL);
   assign stack_empty = (sp_q == '0);
   assign push_idx    = IDX_W'(sp_q);
   assign top_idx     = IDX_W'(sp_q - SP_W'(1));
   // A simultaneous return wins, so the push is suppressed in that case.
   assign push_en     = (state_q == ST_IDLE) && int_enter && !int_return && !stack_full;

   always_ff @(posedge clk) begin
      if (push_en) begin
         stack_mem[push_idx] <= flags_q;
      end
   end

   assign stack_err = stack_err_q;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         flags_q        <= '0;
         mask_q         <= '0;
         upd_ack_q      <= 1'b0;
         eval_valid_q   <= 1'b0;
         branch_taken_q <= 1'b0;
         busy_q         <= 1'b0;
`ifdef FLAG_STACK_EN
         sp_q           <= '0;
         stack_err_q    <= 1'b0;
`endif
      end else begin
         upd_ack_q    <= 1'b0;
         eval_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
`ifdef FLAG_STACK_EN
               if (int_return) begin
                  if (stack_empty) begin
                     stack_err_q <= 1'b1;
                  end else begin
                     flags_q <= stack_mem[top_idx];
                     sp_q    <= sp_q - SP_W'(1);
                  end
               end else if (int_enter) begin
                  if (stack_full) begin
                     stack_err_q <= 1'b1;
                  end else begin
                     sp_q <= sp_q + SP_W'(1);
                  end
               end else
`endif
               if (upd_req) begin
                  mask_q  <= upd_mask;
                  busy_q  <= 1'b1;
                  state_q <= ST_WAIT_ALU;
               end else if (eval_req) begin
                  branch_taken_q <= taken;
                  eval_valid_q   <= 1'b1;
                  busy_q         <= 1'b1;
                  state_q        <= ST_EVAL;
               end
            end
            ST_WAIT_ALU: begin
               if (alu_done) begin
                  flags_q   <= flags_merge_d;
                  upd_ack_q <= 1'b1;
                  state_q   <= ST_UPD_DONE;
               end
            end
            ST_UPD_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            ST_EVAL: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign upd_ack      = upd_ack_q;
   assign eval_valid   = eval_valid_q;
   assign branch_taken = branch_taken_q;
   assign flags        = flags_q;
   assign busy         = busy_q;

endmodule
